// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : LSB-first UART frame serializer, one bit per baud_tick pulse.
//            Optional parity stage compiled in with UART_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                 c_IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [c_IDX_W-1:0]   w_bit_idx_nxt;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
    logic                 w_parity_nxt;
`else
    logic                 w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    // The shift register is consumed from bit 0: each emitted data bit shifts it right.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt   = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (tx_valid) begin
                    w_shift_nxt  = tx_data;
                    w_state_nxt  = ST_ARMED;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = (^tx_data) ^ PARITY_ODD;
`endif
                end
            end
            // Accept never starts the start bit directly, so it always gets a full period.
            ST_ARMED: begin
                if (baud_tick) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (r_bit_idx == c_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt       = r_parity;
                        w_state_nxt    = ST_PARITY;
`else
                        w_tx_nxt       = 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                        w_state_nxt    = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (r_stop_cnt == c_LAST_STOP) begin
                        w_tx_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = (r_state == ST_IDLE);
    assign tx_busy  = (r_state != ST_IDLE);
    assign tx_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Self-checking bench for uart_tx_serializer (1-stop and 2-stop/odd
//            instances); frames predicted as bit lists from the frame format.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       valid1, valid2;
    logic       ready1, tx1, busy1, done1;
    logic       ready2, tx2, busy2, done2;

    int checks    = 0;
    int failures  = 0;
    int tick_per  = 8;
    int tick_cnt  = 0;
    int cyc       = 0;
    int last_fall = 0;
    int last_done = 0;

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(valid1), .tx_ready(ready1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(valid2), .tx_ready(ready2), .tx(tx2), .tx_busy(busy2), .tx_done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick: one-clk pulse every tick_per clocks (continuous when tick_per == 1).
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_per - 1) begin
                tick_cnt  = 0;
                baud_tick = 1'b1;
            end else begin
                tick_cnt  = tick_cnt + 1;
                baud_tick = 1'b0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic g_tx(input int w);    return (w != 0) ? tx2    : tx1;    endfunction
    function automatic logic g_ready(input int w); return (w != 0) ? ready2 : ready1; endfunction
    function automatic logic g_busy(input int w);  return (w != 0) ? busy2  : busy1;  endfunction
    function automatic logic g_done(input int w);  return (w != 0) ? done2  : done1;  endfunction

    task automatic set_valid(input int w, input logic v);
        if (w != 0) valid2 = v;
        else        valid1 = v;
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            for (int w = 0; w < 2; w++) begin
                chk("idle_tx",    {31'd0, g_tx(w)},    32'd1);
                chk("idle_ready", {31'd0, g_ready(w)}, 32'd1);
                chk("idle_busy",  {31'd0, g_busy(w)},  32'd0);
                chk("idle_done",  {31'd0, g_done(w)},  32'd0);
            end
        end
    endtask

    // Sends one byte on instance w and checks tx/busy/done every clock against the
    // expected bit list. hold keeps tx_valid high with nxt on tx_data after accept.
    // abort_at > 0 returns right after the tick that starts frame bit abort_at-1.
    task automatic send_frame(input int w, input logic [7:0] data, input bit hold,
                              input logic [7:0] nxt, input int abort_at);
        logic q[$];
        int   nbits, k, guard, ones, fall_cyc, stops;
        logic tk, exp_tx;
        stops = (w != 0) ? 2 : 1;
        ones  = 0;
        q     = {};
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(data[i]);
            ones += int'(data[i]);
        end
`ifdef UART_TX_PARITY_EN
        q.push_back(logic'((ones % 2) ^ ((w != 0) ? 1 : 0)));
`endif
        for (int i = 0; i < stops; i++) q.push_back(1'b1);
        nbits = q.size();

        guard = 0;
        while (!g_ready(w) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_wait", {31'd0, g_ready(w)}, 32'd1);
        set_valid(w, 1'b1);
        tx_data = data;
        @(posedge clk); #1;
        if (hold) tx_data = nxt;
        else      set_valid(w, 1'b0);
        chk("accept_ready", {31'd0, g_ready(w)}, 32'd0);
        chk("accept_tx",    {31'd0, g_tx(w)},    32'd1);
        chk("accept_busy",  {31'd0, g_busy(w)},  32'd1);

        k        = 0;
        guard    = 0;
        fall_cyc = cyc;
        while (k <= nbits && guard < (nbits + 3) * tick_per + 10) begin
            @(posedge clk);
            tk = baud_tick;
            #1;
            guard++;
            if (!hold) tx_data = 8'($urandom);
            if (tk) k++;
            if (tk && k == 1) fall_cyc = cyc;
            exp_tx = (k == 0 || k > nbits) ? 1'b1 : q[k-1];
            chk("frame_tx",   {31'd0, g_tx(w)},   {31'd0, exp_tx});
            chk("frame_busy", {31'd0, g_busy(w)}, {31'd0, logic'(k <= nbits)});
            chk("frame_done", {31'd0, g_done(w)}, {31'd0, logic'(k == nbits + 1)});
            if (abort_at > 0 && k == abort_at) return;
        end
        chk("frame_timeout", k, nbits + 1);
        chk("done_ready", {31'd0, g_ready(w)}, 32'd1);
        chk("frame_len", cyc - fall_cyc, nbits * tick_per);
        last_fall = fall_cyc;
        last_done = cyc;
    endtask

    initial begin
        int         prev_done;
        int         w;
        logic [7:0] d;
        rst     = 1'b0;
        valid1  = 1'b0;
        valid2  = 1'b0;
        tx_data = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_tx",    {31'd0, tx1},    32'd1);
            chk("rst_ready", {31'd0, ready1}, 32'd1);
            chk("rst_busy",  {31'd0, busy1},  32'd0);
            chk("rst_done",  {31'd0, done1},  32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        check_idle(200);

        tick_per = 8;
        send_frame(0, 8'hA5, 1'b0, 8'h00, 0);

        send_frame(0, 8'h00, 1'b1, 8'hFF, 0);
        prev_done = last_done;
        send_frame(0, 8'hFF, 1'b0, 8'h00, 0);
        chk("b2b_gap", last_fall - prev_done, tick_per);

        send_frame(0, 8'h07, 1'b0, 8'h00, 0);
        send_frame(1, 8'hA5, 1'b0, 8'h00, 0);
        send_frame(1, 8'h3C, 1'b0, 8'h00, 0);

        tick_per = 1;
        send_frame(0, 8'h96, 1'b0, 8'h00, 0);
        send_frame(1, 8'h4B, 1'b0, 8'h00, 0);

        // Reset during data bit 3 of 0x55: line must return high at once.
        tick_per = 8;
        send_frame(0, 8'h55, 1'b0, 8'h00, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_tx",    {31'd0, tx1},    32'd1);
        chk("midrst_ready", {31'd0, ready1}, 32'd1);
        chk("midrst_busy",  {31'd0, busy1},  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_done", {31'd0, done1}, 32'd0);
            chk("midrst_hold", {31'd0, tx1},   32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        check_idle(20);
        send_frame(0, 8'h81, 1'b0, 8'h00, 0);

        for (int n = 0; n < 24; n++) begin
            tick_per = int'($urandom_range(1, 6));
            w        = int'($urandom_range(0, 1));
            d        = 8'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) begin
                @(posedge clk); #1;
            end
            send_frame(w, d, 1'b0, 8'h00, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
